aes64_round: RTL and testbench
==============================

// Module: aes64_round
// PURPOSE
// - One registered round of the 64-bit nibble-oriented Simplified-AES cipher datapath.
// - Round sequence: SubNibbles -> ShiftRows -> MixColumns (skipped when last_round=1) -> AddRoundKey.
// - The cipher controller iterates this stage, feeding nextState back as currentState with a fresh roundKey.
// PARAMETERS
// - none; state width is fixed at 64 bits (16 nibbles).
// PORTS
// - clk           in   1   single clock, rising edge
// - rst           in   1   asynchronous, active-high reset
// - in_valid      in   1   currentState/roundKey/last_round are valid this cycle
// - last_round    in   1   1 = omit MixColumns (final cipher round)
// - currentState  in   64  round input state
// - roundKey      in   64  round key
// - nextState     out  64  registered round output
// - out_valid     out  1   nextState holds a new result
// BEHAVIOUR
// - Reset (async, rst=1): nextState=64'h0, out_valid=0; held while rst is high.
// - Latency is 1 cycle. in_valid=1 at edge k -> nextState updated and out_valid=1 after edge k.
// - in_valid=0 at an edge -> out_valid=0 and nextState holds its previous value.
// - No backpressure. A new input is accepted every cycle.
// - Reset asserted mid-operation discards the result in flight.
// - Nibble layout: nibble i = state[63-4i -: 4], i=0..15, at row i%4, column i/4 (column-major).
// - SubNibbles S-box, input 0..F maps to: 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
// - ShiftRows: row r is rotated left by r columns (r=0..3).
// - MixColumns: arithmetic in GF(2^4), polynomial x^4+x+1; addition is XOR.
//   - Each column [a0..a3] is multiplied by matrix rows [2 3 1 1],[1 2 3 1],[1 1 2 3],[3 1 1 2].
//   - xtime(b) = {b[2:0],1'b0} ^ (b[3] ? 4'h3 : 4'h0); 3*b = xtime(b)^b.
// - AddRoundKey: bitwise XOR of all 64 bits with roundKey.
// - Datapath is combinational from the inputs to the nextState register; there is no other state.
// TESTING
// - Reset: assert rst with in_valid=1 -> nextState=0, out_valid=0; release rst -> the first result appears 1 cycle later.
// - last_round=0, state=0, key=0 -> nextState=64'h9999999999999999 one cycle later.
// - last_round=0, state=all F, key=all F -> 64'h8888888888888888.
// - last_round=0, state=all A, key=all 5 -> 64'h5555555555555555.
// - last_round=0, state=all 9, key=all 1 -> 64'h3333333333333333.
// - last_round=1, state=64'h0123456789ABCDEF, key=0 -> 64'h9107D2FB6EA5C483.
// - Back-to-back: apply the vectors above on consecutive cycles -> results on consecutive cycles.
// - Drop in_valid -> out_valid=0 and nextState holds.

Source files
------------

// File: rtl/aes64_round.sv
// One registered round of 64-bit nibble Simplified-AES: SubNibbles, ShiftRows, MixColumns, AddRoundKey.
// Result is registered one cycle after in_valid; there is no backpressure, so an input is accepted every cycle.
module aes64_round (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        last_round,
   input  logic [63:0] currentState,
   input  logic [63:0] roundKey,
   output logic [63:0] nextState,
   output logic        out_valid
);

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
         4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
         4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
         4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
      endcase
      return y;
   endfunction

   // Multiply by x in GF(2^4) modulo x^4+x+1.
   function automatic logic [3:0] xtime(input logic [3:0] b);
      return {b[2:0], 1'b0} ^ (b[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] mul3(input logic [3:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] k,
                                            input logic last);
      logic [3:0] sn [16];
      logic [3:0] sr [16];
      logic [3:0] mc [16];
      logic [63:0] res;
      // Index i = 4*col + row, nibble 0 in the most significant position.
      for (int i = 0; i < 16; i++) begin
         sn[i] = sbox(s[63-4*i -: 4]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c + r] = sn[4*((c + r) % 4) + r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = xtime(sr[4*c+0]) ^ mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ mul3(sr[4*c+3]);
         mc[4*c+3] = mul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      res = 64'h0;
      for (int i = 0; i < 16; i++) begin
         res[63-4*i -: 4] = last ? sr[i] : mc[i];
      end
      return res ^ k;
   endfunction

   logic [63:0] round_out;

   always_comb begin
      round_out = round_fn(currentState, roundKey, last_round);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nextState <= 64'h0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            nextState <= round_out;
         end
      end
   end

endmodule

// File: tb/tb_aes64_round.sv
// Directed-vector bench for aes64_round with hand-computed round results.
module tb_aes64_round;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        last_round;
   logic [63:0] currentState;
   logic [63:0] roundKey;
   logic [63:0] nextState;
   logic        out_valid;

   int n_total = 0;
   int n_bad   = 0;

   aes64_round dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .last_round   (last_round),
      .currentState (currentState),
      .roundKey     (roundKey),
      .nextState    (nextState),
      .out_valid    (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   typedef struct {
      logic        last;
      logic [63:0] st;
      logic [63:0] key;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{1'b0, 64'h0000000000000000, 64'h0000000000000000, 64'h9999999999999999};
      vecs[1] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h8888888888888888};
      vecs[2] = '{1'b0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h5555555555555555};
      vecs[3] = '{1'b0, 64'h9999999999999999, 64'h1111111111111111, 64'h3333333333333333};
      vecs[4] = '{1'b1, 64'h0123456789ABCDEF, 64'h0000000000000000, 64'h9107D2FB6EA5C483};
      vecs[5] = '{1'b0, 64'h0123456789ABCDEF, 64'h0000000000000000, 64'h5C17B0CC2104CCED};
      vecs[6] = '{1'b1, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h6EF82D04915A3B7C};

      // Reset held with a valid input present.
      rst          = 1'b1;
      in_valid     = 1'b1;
      last_round   = 1'b0;
      currentState = 64'h0123456789ABCDEF;
      roundKey     = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", nextState, 64'h0);
      check("rst_valid", {63'h0, out_valid}, 64'h0);

      rst          = 1'b0;
      currentState = vecs[0].st;
      roundKey     = vecs[0].key;
      last_round   = vecs[0].last;
      check("pre_first_valid", {63'h0, out_valid}, 64'h0);
      @(posedge clk);
      #1;
      check("first_state", nextState, vecs[0].exp);
      check("first_valid", {63'h0, out_valid}, 64'h1);

      // Back-to-back vectors, one per cycle.
      for (int i = 1; i < 7; i++) begin
         currentState = vecs[i].st;
         roundKey     = vecs[i].key;
         last_round   = vecs[i].last;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_state", i), nextState, vecs[i].exp);
         check($sformatf("vec%0d_valid", i), {63'h0, out_valid}, 64'h1);
      end

      // Idle: output holds while inputs change.
      in_valid     = 1'b0;
      currentState = 64'hDEADBEEFCAFEF00D;
      roundKey     = 64'h123456789ABCDEF0;
      repeat (2) begin
         @(posedge clk);
         #1;
         check("idle_valid", {63'h0, out_valid}, 64'h0);
         check("idle_hold", nextState, vecs[6].exp);
      end

      // Resume with a single vector after idle.
      in_valid     = 1'b1;
      currentState = vecs[1].st;
      roundKey     = vecs[1].key;
      last_round   = vecs[1].last;
      @(posedge clk);
      #1;
      check("resume_state", nextState, vecs[1].exp);
      check("resume_valid", {63'h0, out_valid}, 64'h1);

      // Reset between edges clears at once and discards the input in flight.
      currentState = vecs[2].st;
      roundKey     = vecs[2].key;
      last_round   = vecs[2].last;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_state", nextState, 64'h0);
      check("async_rst_valid", {63'h0, out_valid}, 64'h0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("discard_state", nextState, 64'h0);
      check("discard_valid", {63'h0, out_valid}, 64'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
